// File: rtl/router_pkg.sv
// Shared router definitions: flit_id codes, default flit width, length field and
// the input-buffer packet FSM state type.
package router_pkg;

  localparam int FLIT_W_DEF = 32;
  localparam int ID_W       = 3;

  localparam logic [ID_W-1:0] ID_HEADER = 3'b001;
  localparam logic [ID_W-1:0] ID_BODY   = 3'b010;
  localparam logic [ID_W-1:0] ID_TAIL   = 3'b100;

  localparam int LEN_LSB = 0;
  localparam int LEN_W   = 12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_XFER = 2'd2
  } state_e;

endpackage

// File: rtl/flit_fifo.sv
// Flit storage for one input port: circular buffer with wrap-around pointers.
// A push is refused while full, even when a pop happens in the same cycle.
module flit_fifo #(
  parameter int FLIT_W = 32,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [FLIT_W-1:0]        wr_data_i,
  input  logic                     pop_i,
  output logic [FLIT_W-1:0]        rd_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [FLIT_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       count_q;
  logic              do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;

endmodule

// File: rtl/input_buffer.sv
// Router input port: flit FIFO plus packet FSM that requests the arbiter and
// streams a granted packet, discarding flits that cannot start a packet.
//   state   | meaning
//   ST_IDLE | waiting for a HEADER at the head; other flits are dropped
//   ST_REQ  | packet pending, req high, waiting for grant
//   ST_XFER | granted, head flits leave while grant holds, TAIL pop ends packet
module input_buffer
  import router_pkg::*;
#(
  parameter int FLIT_W = FLIT_W_DEF,
  parameter int DEPTH  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [FLIT_W-1:0]      in_flit,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic                   req,
  output logic [ID_W-1:0]        flit_id,
  output logic [LEN_W-1:0]       length,
  input  logic                   grant,
  input  logic                   out_ready,
  output logic [FLIT_W-1:0]      out_flit,
  output logic                   out_valid,
  output logic                   drop_err,
  output logic [$clog2(DEPTH):0] occupancy
);

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  length_q;
  logic              rdy_q;
  logic [FLIT_W-1:0] head_flit;
  logic [ID_W-1:0]   head_id;
  logic              full, empty, push, pop;

  flit_fifo #(.FLIT_W(FLIT_W), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_i    (push),
    .wr_data_i (in_flit),
    .pop_i     (pop),
    .rd_data_o (head_flit),
    .full_o    (full),
    .empty_o   (empty),
    .count_o   (occupancy)
  );

  assign head_id  = head_flit[FLIT_W-1 -: ID_W];
  // rdy_q keeps the port closed for the first cycle after reset release
  assign in_ready = rdy_q & ~full;
  assign push     = in_valid & in_ready;
  assign out_flit = head_flit;
  assign length   = length_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      length_q <= '0;
      rdy_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rdy_q   <= 1'b1;
      if (state_q == ST_IDLE && state_d == ST_REQ)
        length_q <= head_flit[LEN_LSB +: LEN_W];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (!empty && head_id == ID_HEADER) state_d = ST_REQ;
      ST_REQ:  if (grant) state_d = ST_XFER;
      ST_XFER: begin
        if (!grant)                                           state_d = ST_REQ;
        else if (!empty && out_ready && head_id == ID_TAIL)   state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req       = (state_q != ST_IDLE);
    out_valid = (state_q == ST_XFER) & grant & ~empty;
    drop_err  = (state_q == ST_IDLE) & ~empty & (head_id != ID_HEADER);
    pop       = drop_err | (out_valid & out_ready);
    flit_id   = (req && !empty) ? head_id : '0;
  end

endmodule

// File: tb/tb_input_buffer.sv
// Bench for input_buffer: directed vector table, hand-written corner sequences
// and a randomized run against a queue-based packet model.
module tb_input_buffer;

  localparam int FW    = 32;
  localparam int DEPTH = 8;
  localparam int OW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [FW-1:0] in_flit = '0;
  logic          in_valid = 1'b0;
  logic          grant = 1'b0;
  logic          out_ready = 1'b0;
  logic          in_ready, req, out_valid, drop_err;
  logic [2:0]    flit_id;
  logic [11:0]   length;
  logic [FW-1:0] out_flit;
  logic [OW-1:0] occupancy;

  input_buffer #(.FLIT_W(FW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_flit   (in_flit),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .req       (req),
    .flit_id   (flit_id),
    .length    (length),
    .grant     (grant),
    .out_ready (out_ready),
    .out_flit  (out_flit),
    .out_valid (out_valid),
    .drop_err  (drop_err),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [FW-1:0] mk(input logic [2:0] id, input logic [28:0] payload);
    return {id, payload};
  endfunction

  task automatic do_reset();
    rst = 1'b0; in_valid = 1'b0; grant = 1'b0; out_ready = 1'b0;
    tick();
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_req", req, 0);
    chk("rst_occ", occupancy, 0);
    rst = 1'b1;
    tick();
    #1;
    chk("post_rst_in_ready", in_ready, 1);
  endtask

  typedef struct {
    logic        iv;
    logic [31:0] fl;
    logic        g;
    logic        ordy;
    logic        e_req;
    logic        e_ov;
    logic [2:0]  e_fid;
    logic [3:0]  e_occ;
    logic [11:0] e_len;
    logic [31:0] e_fl;
  } vec_t;

  vec_t tbl[7];

  // model state for the random run
  logic [FW-1:0] q[$];
  bit            busy, moving;
  logic [11:0]   len_m;

  initial begin
    logic [FW-1:0] fh, fb, ft;
    fh = mk(3'b001, 29'h0000_005);
    fb = mk(3'b010, 29'h0000_abc);
    ft = mk(3'b100, 29'h0001_234);

    //          iv  flit  g  ordy req ov fid  occ len     flit
    tbl[0] = '{1'b1, fh, 1'b1, 1'b1, 0, 0, 3'd0, 0, 12'h000, 32'h0};
    tbl[1] = '{1'b1, fb, 1'b1, 1'b1, 0, 0, 3'd0, 1, 12'h000, 32'h0};
    tbl[2] = '{1'b1, ft, 1'b1, 1'b1, 1, 0, 3'd1, 2, 12'h005, 32'h0};
    tbl[3] = '{1'b0, 0,  1'b1, 1'b1, 1, 1, 3'd1, 3, 12'h005, fh};
    tbl[4] = '{1'b0, 0,  1'b1, 1'b1, 1, 1, 3'd2, 2, 12'h005, fb};
    tbl[5] = '{1'b0, 0,  1'b1, 1'b1, 1, 1, 3'd4, 1, 12'h005, ft};
    tbl[6] = '{1'b0, 0,  1'b1, 1'b1, 0, 0, 3'd0, 0, 12'h005, 32'h0};

    // basic packet through an empty buffer
    do_reset();
    for (int i = 0; i < 7; i++) begin
      in_valid = tbl[i].iv; in_flit = tbl[i].fl; grant = tbl[i].g; out_ready = tbl[i].ordy;
      #1;
      chk($sformatf("tbl%0d_req", i), req, tbl[i].e_req);
      chk($sformatf("tbl%0d_ov", i), out_valid, tbl[i].e_ov);
      chk($sformatf("tbl%0d_fid", i), flit_id, tbl[i].e_fid);
      chk($sformatf("tbl%0d_occ", i), occupancy, tbl[i].e_occ);
      chk($sformatf("tbl%0d_len", i), length, tbl[i].e_len);
      chk($sformatf("tbl%0d_rdy", i), in_ready, 1);
      if (tbl[i].e_ov) chk($sformatf("tbl%0d_flit", i), out_flit, tbl[i].e_fl);
      tick();
    end

    // fill to full, ninth flit refused, then one pop reopens the port
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1;
      in_flit  = (i == 0) ? mk(3'b001, 29'h7) : mk(3'b010, 29'(i));
      #1;
      if (i == 8) chk("full_in_ready_9th", in_ready, 0);
      tick();
    end
    in_valid = 1'b0;
    #1;
    chk("full_occ", occupancy, 8);
    chk("full_in_ready", in_ready, 0);
    grant = 1'b1;
    tick();
    #1;
    chk("full_pop_ov", out_valid, 1);
    chk("full_pop_flit", out_flit, mk(3'b001, 29'h7));
    tick();
    grant = 1'b0;
    #1;
    chk("after_pop_in_ready", in_ready, 1);
    chk("after_pop_occ", occupancy, 7);
    grant = 1'b1;
    for (int j = 1; j <= 7; j++) begin
      #1;
      chk($sformatf("drain%0d_flit", j), out_flit, mk(3'b010, 29'(j)));
      tick();
    end
    #1;
    chk("drain_empty_ov", out_valid, 0);
    chk("drain_empty_req", req, 1);
    chk("drain_empty_occ", occupancy, 0);

    // grant withdrawn mid-packet, then regranted
    do_reset();
    out_ready = 1'b1;
    in_valid = 1'b1; in_flit = mk(3'b001, 29'h03a); tick();
    in_flit = mk(3'b010, 29'h11); tick();
    in_flit = mk(3'b100, 29'h22); tick();
    in_valid = 1'b0;
    grant = 1'b1;
    tick();
    #1;
    chk("regr_hdr_flit", out_flit, mk(3'b001, 29'h03a));
    chk("regr_len", length, 12'h03a);
    tick();
    grant = 1'b0;
    #1;
    chk("regr_drop_ov", out_valid, 0);
    chk("regr_drop_req", req, 1);
    chk("regr_drop_fid", flit_id, 3'b010);
    tick();
    #1;
    chk("regr_wait_ov", out_valid, 0);
    chk("regr_wait_req", req, 1);
    chk("regr_wait_occ", occupancy, 2);
    grant = 1'b1;
    tick();
    #1;
    chk("regr_body", out_flit, mk(3'b010, 29'h11));
    chk("regr_body_ov", out_valid, 1);
    tick();
    #1;
    chk("regr_tail", out_flit, mk(3'b100, 29'h22));
    tick();
    #1;
    chk("regr_end_req", req, 0);
    chk("regr_end_occ", occupancy, 0);

    // BODY at head while idle is discarded
    do_reset();
    in_valid = 1'b1; in_flit = mk(3'b010, 29'h55); tick();
    in_valid = 1'b0;
    #1;
    chk("drop_pulse", drop_err, 1);
    chk("drop_occ1", occupancy, 1);
    chk("drop_req1", req, 0);
    tick();
    #1;
    chk("drop_clear", drop_err, 0);
    chk("drop_occ0", occupancy, 0);
    chk("drop_req0", req, 0);

    // reset asserted mid-transfer acts immediately
    do_reset();
    grant = 1'b1;
    in_valid = 1'b1; in_flit = mk(3'b001, 29'h009); tick();
    in_flit = mk(3'b010, 29'h1); tick();
    in_valid = 1'b0;
    tick();
    #1;
    chk("mid_xfer_ov", out_valid, 1);
    rst = 1'b0;
    #1;
    chk("async_req", req, 0);
    chk("async_ov", out_valid, 0);
    chk("async_occ", occupancy, 0);
    chk("async_in_ready", in_ready, 0);
    chk("async_fid", flit_id, 0);
    chk("async_len", length, 0);
    chk("async_drop", drop_err, 0);
    tick();
    rst = 1'b1;
    tick();
    #1;
    chk("rel_occ", occupancy, 0);
    chk("rel_in_ready", in_ready, 1);
    chk("rel_req", req, 0);

    // randomized traffic against the packet model
    do_reset();
    q.delete(); busy = 0; moving = 0; len_m = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      logic [2:0]    id;
      logic [FW-1:0] head;
      bit            e_ov, e_drop, popped, accept;
      int unsigned   r;
      r = $urandom_range(0, 9);
      id = (r < 3) ? 3'b001 : (r < 7) ? 3'b010 : (r < 9) ? 3'b100 : 3'($urandom_range(0, 1) * 7);
      in_valid  = ($urandom_range(0, 99) < 55);
      in_flit   = {id, 17'($urandom), 12'($urandom)};
      grant     = ($urandom_range(0, 99) < 70);
      out_ready = ($urandom_range(0, 99) < 70);
      #1;
      head   = (q.size() > 0) ? q[0] : '0;
      e_ov   = busy && moving && grant && q.size() > 0;
      e_drop = !busy && q.size() > 0 && head[FW-1 -: 3] != 3'b001;
      chk("rnd_in_ready", in_ready, q.size() < DEPTH);
      chk("rnd_req", req, busy);
      chk("rnd_ov", out_valid, e_ov);
      chk("rnd_drop", drop_err, e_drop);
      chk("rnd_occ", occupancy, q.size());
      chk("rnd_fid", flit_id, (busy && q.size() > 0) ? head[FW-1 -: 3] : 3'b000);
      chk("rnd_len", length, len_m);
      if (e_ov) chk("rnd_flit", out_flit, head);

      accept = in_valid && q.size() < DEPTH;
      popped = 0;
      if (!busy) begin
        if (q.size() > 0) begin
          if (head[FW-1 -: 3] == 3'b001) begin busy = 1; len_m = head[11:0]; end
          else popped = 1;
        end
      end else if (!moving) begin
        if (grant) moving = 1;
      end else if (!grant) begin
        moving = 0;
      end else if (q.size() > 0 && out_ready) begin
        popped = 1;
        if (head[FW-1 -: 3] == 3'b100) begin busy = 0; moving = 0; end
      end
      if (popped) void'(q.pop_front());
      if (accept) q.push_back(in_flit);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/input_buffer.md
INPUT_BUFFER -- requirements
Module: input_buffer

Interface
REQ-001 Parameter FLIT_W, default 32, flit width; bits [FLIT_W-1:FLIT_W-3] hold flit_id and header bits [11:0] hold packet length.
REQ-002 Parameter DEPTH, default 8, FIFO depth in flits, power of two, 2..64.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 in_flit  in  FLIT_W  flit from upstream link.
REQ-006 in_valid  in  1  in_flit valid.
REQ-007 in_ready  out  1  buffer accepts a flit this cycle.
REQ-008 req  out  1  request to the port arbiter.
REQ-009 flit_id  out  3  flit_id of the head flit, feeding the arbiter timer.
REQ-010 length  out  12  length of the packet currently requesting.
REQ-011 grant  in  1  arbiter grant for this port, the one-hot state bit.
REQ-012 out_ready  in  1  crossbar/downstream accepts a flit.
REQ-013 out_flit  out  FLIT_W  head flit to crossbar.
REQ-014 out_valid  out  1  out_flit valid.
REQ-015 drop_err  out  1  one-cycle pulse when a malformed flit is discarded.
REQ-016 occupancy  out  clog2(DEPTH)+1  flits stored.

Function
REQ-017 flit_id encoding: HEADER 3'b001, BODY 3'b010, TAIL 3'b100; a packet is one HEADER, zero or more BODY, one TAIL.
REQ-018 Push when in_valid and in_ready; in_ready = not full; no write-through when full, even with a simultaneous pop.
REQ-019 Simultaneous push and pop when neither full nor empty leaves occupancy unchanged; pointers wrap modulo DEPTH.
REQ-020 Packet FSM states IDLE, REQ and XFER; req = (state != IDLE).
REQ-021 IDLE: head is HEADER -> REQ; length register loads head[11:0] on that edge.
REQ-022 IDLE: head is BODY/TAIL/other -> flit popped and discarded, drop_err pulses, state stays IDLE.
REQ-023 REQ: grant=1 -> XFER; otherwise hold.
REQ-024 XFER: out_valid = grant and not empty; pop when out_valid and out_ready; out_flit = head flit, combinational from storage.
REQ-025 XFER: grant=0 -> REQ, no pop, in-packet position retained.
REQ-026 XFER: popping the TAIL -> IDLE; req is low the following cycle.
REQ-027 Latency: a HEADER written into an empty buffer at edge k raises req after edge k+1; first flit can leave the cycle grant is seen in XFER.
REQ-028 flit_id = head flit_id when state != IDLE and not empty, else 3'b000.
REQ-029 length holds its value from entry to REQ until the next IDLE->REQ.
REQ-030 Empty in XFER: out_valid=0, state XFER, req stays 1.

Reset
REQ-031 While rst is low: pointers and occupancy 0, state IDLE, length 0, req 0, out_valid 0, drop_err 0, flit_id 0, in_ready 0.
REQ-032 in_ready rises the first cycle after rst deasserts; a reset mid-packet discards the stored flits.

Structure
REQ-033 Shared package router_pkg holds the flit_id encodings, FLIT_W, the length field position, and the FSM state type.
REQ-034 FIFO storage and pointers are the sub-module flit_fifo; the FSM and arbiter-side outputs stay in input_buffer.

Verification
REQ-035 Reset: rst low -> in_ready 0, req 0, occupancy 0; after release, in_ready 1 the next cycle.
REQ-036 Write HEADER(len 12'h005), BODY, TAIL into empty buffer, grant=1, out_ready=1 -> req high 2 cycles after header write, length 5, flit_id 3'b001, three flits out in order on consecutive cycles, req low the cycle after TAIL pop.
REQ-037 Push 9 flits with no grant, DEPTH=8 -> occupancy 8, in_ready 0, 9th flit not accepted; after one pop, in_ready 1 the next cycle.
REQ-038 Drop grant after HEADER pop -> out_valid 0, state REQ, req 1; regrant -> BODY then TAIL delivered.
REQ-039 BODY flit at head in IDLE -> discarded, drop_err one-cycle pulse, occupancy decrements by 1, req stays 0.
REQ-040 Assert rst during XFER -> all outputs at reset values immediately, not at the next edge; occupancy 0 after release.
